// File: rtl/pipe_ctrl_chain.sv
// ID/EX -> EX/MEM -> MEM/WB control and destination-tag chain.
// Feeds hazard/forwarding compares; bubbles, squashes, freezes, perf counters.
module pipe_ctrl_chain #(
  parameter int CTRL_W   = 15,
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              bubble_n,
  input  logic              flush,
  input  logic              freeze,
  output logic              id_ex_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_memread,
  output logic [REG_W-1:0]  id_ex_rs,
  output logic [REG_W-1:0]  id_ex_rt,
  output logic [REG_W-1:0]  id_ex_dst,
  output logic              ex_mem_regwrite,
  output logic              ex_mem_memread,
  output logic              ex_mem_memwrite,
  output logic              ex_mem_memtoreg,
  output logic [REG_W-1:0]  ex_mem_dst,
  output logic              mem_wb_regwrite,
  output logic              mem_wb_memtoreg,
  output logic [REG_W-1:0]  mem_wb_dst,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [REG_W-1:0] LINK = REG_W'(LINK_REG);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dst;
  } id_ex_t;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             memtoreg;
    logic [REG_W-1:0] dst;
  } ex_mem_t;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memtoreg;
    logic [REG_W-1:0] dst;
  } mem_wb_t;

  id_ex_t  id_ex_q, id_ex_nxt;
  ex_mem_t ex_mem_q;
  mem_wb_t mem_wb_q;
  logic [REG_W-1:0] id_dst;
  logic             stall_bub;

  always_comb begin
    if (id_ctrl[3])       id_dst = LINK;
    else if (id_ctrl[10]) id_dst = id_rd;
    else                  id_dst = id_rt;
  end

  // flush outranks the stall; only a stall-bubble is counted
  always_comb begin
    id_ex_nxt = '0;
    stall_bub = 1'b0;
    if (flush) begin
      id_ex_nxt = '0;
    end else if (!bubble_n) begin
      stall_bub = 1'b1;
    end else begin
      id_ex_nxt.valid = id_valid;
      id_ex_nxt.ctrl  = id_valid ? id_ctrl : '0;
      id_ex_nxt.rs    = id_rs;
      id_ex_nxt.rt    = id_rt;
      id_ex_nxt.dst   = id_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q     <= '0;
      ex_mem_q    <= '0;
      mem_wb_q    <= '0;
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else if (!freeze) begin
      id_ex_q           <= id_ex_nxt;
      ex_mem_q.valid    <= id_ex_q.valid;
      ex_mem_q.regwrite <= id_ex_q.ctrl[0];
      ex_mem_q.memread  <= id_ex_q.ctrl[7];
      ex_mem_q.memwrite <= id_ex_q.ctrl[6];
      ex_mem_q.memtoreg <= id_ex_q.ctrl[4];
      ex_mem_q.dst      <= id_ex_q.dst;
      mem_wb_q.valid    <= ex_mem_q.valid;
      mem_wb_q.regwrite <= ex_mem_q.regwrite;
      mem_wb_q.memtoreg <= ex_mem_q.memtoreg;
      mem_wb_q.dst      <= ex_mem_q.dst;
      if (mem_wb_q.valid && retired_cnt != '1)
        retired_cnt <= retired_cnt + 1'b1;
      if (stall_bub && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign id_ex_valid     = id_ex_q.valid;
  assign id_ex_ctrl      = id_ex_q.ctrl;
  assign id_ex_memread   = id_ex_q.ctrl[7];
  assign id_ex_rs        = id_ex_q.rs;
  assign id_ex_rt        = id_ex_q.rt;
  assign id_ex_dst       = id_ex_q.dst;
  assign ex_mem_regwrite = ex_mem_q.regwrite;
  assign ex_mem_memread  = ex_mem_q.memread;
  assign ex_mem_memwrite = ex_mem_q.memwrite;
  assign ex_mem_memtoreg = ex_mem_q.memtoreg;
  assign ex_mem_dst      = ex_mem_q.dst;
  assign mem_wb_regwrite = mem_wb_q.regwrite;
  assign mem_wb_memtoreg = mem_wb_q.memtoreg;
  assign mem_wb_dst      = mem_wb_q.dst;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain: directed cases plus random traffic
// checked against a record-shifting reference pipeline.
module tb_pipe_ctrl_chain;

  localparam int CW = 15;
  localparam int RW = 5;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 1'b0;
  logic [CW-1:0] id_ctrl = '0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic          bubble_n = 1'b1, flush = 1'b0, freeze = 1'b0;
  logic          id_ex_valid, id_ex_memread;
  logic [CW-1:0] id_ex_ctrl;
  logic [RW-1:0] id_ex_rs, id_ex_rt, id_ex_dst;
  logic          ex_mem_regwrite, ex_mem_memread;
  logic          ex_mem_memwrite, ex_mem_memtoreg;
  logic [RW-1:0] ex_mem_dst;
  logic          mem_wb_regwrite, mem_wb_memtoreg;
  logic [RW-1:0] mem_wb_dst;
  logic [NW-1:0] retired_cnt, bubble_cnt;

  pipe_ctrl_chain #(.CTRL_W(CW), .REG_W(RW), .LINK_REG(31), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .bubble_n(bubble_n), .flush(flush), .freeze(freeze),
    .id_ex_valid(id_ex_valid), .id_ex_ctrl(id_ex_ctrl),
    .id_ex_memread(id_ex_memread), .id_ex_rs(id_ex_rs),
    .id_ex_rt(id_ex_rt), .id_ex_dst(id_ex_dst),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
    .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_memtoreg(ex_mem_memtoreg),
    .ex_mem_dst(ex_mem_dst), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_memtoreg(mem_wb_memtoreg), .mem_wb_dst(mem_wb_dst),
    .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    bit [14:0] ctrl;
    int       rs, rt, dst;
  } rec_t;

  rec_t m[3];
  int   m_ret, m_bub;
  int   passed = 0, total = 0;

  function automatic rec_t blank();
    rec_t r;
    r.valid = 0; r.ctrl = 0; r.rs = 0; r.rt = 0; r.dst = 0;
    return r;
  endfunction

  function automatic int sat_inc(int v);
    return (v >= (1 << NW) - 1) ? v : v + 1;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".id_ex_valid"}, int'(id_ex_valid), int'(m[0].valid));
    chk({tag, ".id_ex_ctrl"}, int'(id_ex_ctrl), int'(m[0].ctrl));
    chk({tag, ".id_ex_memread"}, int'(id_ex_memread), int'(m[0].ctrl[7]));
    chk({tag, ".id_ex_rs"}, int'(id_ex_rs), m[0].rs);
    chk({tag, ".id_ex_rt"}, int'(id_ex_rt), m[0].rt);
    chk({tag, ".id_ex_dst"}, int'(id_ex_dst), m[0].dst);
    chk({tag, ".ex_mem_regwrite"}, int'(ex_mem_regwrite), int'(m[1].ctrl[0]));
    chk({tag, ".ex_mem_memread"}, int'(ex_mem_memread), int'(m[1].ctrl[7]));
    chk({tag, ".ex_mem_memwrite"}, int'(ex_mem_memwrite), int'(m[1].ctrl[6]));
    chk({tag, ".ex_mem_memtoreg"}, int'(ex_mem_memtoreg), int'(m[1].ctrl[4]));
    chk({tag, ".ex_mem_dst"}, int'(ex_mem_dst), m[1].dst);
    chk({tag, ".mem_wb_regwrite"}, int'(mem_wb_regwrite), int'(m[2].ctrl[0]));
    chk({tag, ".mem_wb_memtoreg"}, int'(mem_wb_memtoreg), int'(m[2].ctrl[4]));
    chk({tag, ".mem_wb_dst"}, int'(mem_wb_dst), m[2].dst);
    chk({tag, ".retired_cnt"}, int'(retired_cnt), m_ret);
    chk({tag, ".bubble_cnt"}, int'(bubble_cnt), m_bub);
  endtask

  // One clock: drive inputs, advance reference, compare after the edge
  task automatic step(string tag, bit r, bit v, bit [14:0] c,
                      int rs, int rt, int rd, bit bn, bit fl, bit fz);
    rec_t n;
    rst = r; id_valid = v; id_ctrl = c;
    id_rs = RW'(rs); id_rt = RW'(rt); id_rd = RW'(rd);
    bubble_n = bn; flush = fl; freeze = fz;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) m[i] = blank();
      m_ret = 0; m_bub = 0;
    end else if (!fz) begin
      if (m[2].valid) m_ret = sat_inc(m_ret);
      m[2] = m[1];
      m[1] = m[0];
      n = blank();
      if (!fl && !bn) m_bub = sat_inc(m_bub);
      if (!fl && bn) begin
        n.valid = v;
        n.ctrl = v ? c : 15'h0;
        n.rs = rs; n.rt = rt;
        n.dst = c[3] ? 31 : (c[10] ? rd : rt);
      end
      m[0] = n;
    end
    #1;
    chk_all(tag);
  endtask

  task automatic idle(string tag);
    step(tag, 0, 0, 15'h0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic do_reset(string tag);
    step(tag, 1, 0, 15'h0, 0, 0, 0, 1, 0, 0);
    step(tag, 1, 0, 15'h0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic rand_step(string tag, int rst_pct);
    bit r, fz, fl, bn;
    r  = ($urandom_range(99) < rst_pct);
    fz = ($urandom_range(99) < 10);
    fl = ($urandom_range(99) < 10);
    bn = ($urandom_range(99) >= 15);
    step(tag, r, 1'($urandom), 15'($urandom),
         $urandom_range(31), $urandom_range(31), $urandom_range(31),
         bn, fl, fz);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m[i] = blank();
    m_ret = 0; m_bub = 0;

    do_reset("init_rst");
    for (int i = 0; i < 20; i++) rand_step("pre_rst", 0);
    do_reset("rst_after_traffic");
    chk("rst.retired_zero", int'(retired_cnt), 0);
    chk("rst.bubble_zero", int'(bubble_cnt), 0);
    chk("rst.id_ex_ctrl_zero", int'(id_ex_ctrl), 0);

    // R-type add then jal: link beats Regdst
    step("add", 0, 1, 15'h0401, 1, 2, 7, 1, 0, 0);
    step("jal", 0, 1, 15'h0029, 0, 4, 9, 1, 0, 0);
    chk("add.ex_mem_dst", int'(ex_mem_dst), 7);
    chk("add.ex_mem_regwrite", int'(ex_mem_regwrite), 1);
    idle("link_i1");
    idle("link_i2");
    chk("jal.mem_wb_dst", int'(mem_wb_dst), 31);
    chk("jal.mem_wb_regwrite", int'(mem_wb_regwrite), 1);

    // load-use bubble
    do_reset("lu_rst");
    step("lw", 0, 1, 15'h4091, 2, 3, 0, 1, 0, 0);
    chk("lw.id_ex_memread", int'(id_ex_memread), 1);
    chk("lw.id_ex_rt", int'(id_ex_rt), 3);
    step("lu_stall", 0, 1, 15'h0401, 3, 5, 6, 0, 0, 0);
    chk("lu.id_ex_valid", int'(id_ex_valid), 0);
    chk("lu.id_ex_ctrl", int'(id_ex_ctrl), 0);
    chk("lu.id_ex_dst", int'(id_ex_dst), 0);
    chk("lu.bubble_cnt", int'(bubble_cnt), 1);
    chk("lu.ex_mem_regwrite", int'(ex_mem_regwrite), 1);
    chk("lu.ex_mem_dst", int'(ex_mem_dst), 3);

    // flush and stall on the same edge
    step("fl_st", 0, 1, 15'h0401, 3, 5, 6, 0, 1, 0);
    chk("fl_st.id_ex_ctrl", int'(id_ex_ctrl), 0);
    chk("fl_st.bubble_cnt", int'(bubble_cnt), 1);

    // freeze mid-stream
    step("fz_a", 0, 1, 15'h0401, 1, 2, 10, 1, 0, 0);
    step("fz_b", 0, 1, 15'h0029, 1, 2, 11, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("fz_hold", 0, 1, 15'h4091, 8, 9, 12, 0, 1, 1);
    chk("fz.ex_mem_dst", int'(ex_mem_dst), 10);
    chk("fz.id_ex_dst", int'(id_ex_dst), 31);
    idle("fz_resume1");
    chk("fz.resume_mem_wb_dst", int'(mem_wb_dst), 10);
    idle("fz_resume2");

    // retire-counter saturation at 15
    do_reset("sat_rst");
    for (int i = 0; i < 20; i++)
      step("sat_issue", 0, 1, 15'h0401, i % 32, 1, 2, 1, 0, 0);
    for (int i = 0; i < 4; i++) idle("sat_drain");
    chk("sat.retired_cnt", int'(retired_cnt), 15);

    // random traffic including mid-stream resets
    do_reset("rnd_rst");
    for (int i = 0; i < 400; i++) rand_step("rnd", 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
